// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: HI/LO multiply/divide unit controller.
//
// Accepts one operation per start pulse while idle. MULT/MULTU/DIV/DIVU
// latch their operands, hold busy for a fixed number of cycles and then
// commit the result to HI/LO. MTHI/MTLO write HI/LO directly from D1.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous, active-high
//   start  : one-cycle request, sampled with md_op/D1/D2
//   md_op  : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   D1     : rs operand (dividend / multiplicand / MTHI-MTLO source)
//   D2     : rt operand (divisor / multiplier)
//   busy   : operation in flight (registered, decoded from state)
//   HI, LO : architectural result registers
//
// state | meaning
// IDLE  | no operation in flight, start accepted
// BUSY  | cnt counting down, result committed on the edge where cnt==1
module mult_div_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] a_q, a_nxt;
  logic [31:0] b_q, b_nxt;
  logic [2:0]  op_q, op_nxt;
  logic [31:0] hi_nxt, lo_nxt;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b;
  logic        div_zero, div_ovf;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        res_wr;
  logic [31:0] res_hi, res_lo;

  // Arithmetic works only from the latched operands, so D1/D2 may change
  // freely while busy.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // A zero divisor never commits; substituting 1 keeps the divider inputs
  // defined so no X reaches the result muxes.
  assign div_zero = (b_q == 32'd0);
  assign div_b    = div_zero ? 32'd1 : b_q;
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = '0;
    rem_s = '0;
    if (div_ovf) begin
      // Most-negative / -1 wraps back to the dividend with zero remainder.
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = $signed(a_q) / $signed(div_b);
      rem_s = $signed(a_q) % $signed(div_b);
    end
  end

  assign quo_u = a_q / div_b;
  assign rem_u = a_q % div_b;

  always_comb begin
    res_wr = 1'b0;
    res_hi = HI;
    res_lo = LO;
    case (op_q)
      OP_MULT: begin
        res_wr = 1'b1;
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_wr = 1'b1;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_wr = !div_zero;
        res_hi = rem_s;
        res_lo = quo_s;
      end
      OP_DIVU: begin
        res_wr = !div_zero;
        res_hi = rem_u;
        res_lo = quo_u;
      end
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    hi_nxt    = HI;
    lo_nxt    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              a_nxt     = D1;
              b_nxt     = D2;
              op_nxt    = md_op;
              cnt_nxt   = 4'(MULT_LAT);
              state_nxt = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              a_nxt     = D1;
              b_nxt     = D2;
              op_nxt    = md_op;
              cnt_nxt   = 4'(DIV_LAT);
              state_nxt = BUSY;
            end
            OP_MTHI: hi_nxt = D1;
            OP_MTLO: lo_nxt = D1;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // start is ignored here, including MTHI/MTLO.
        cnt_nxt = cnt - 4'd1;
        // <= rather than == so a corrupted zero count cannot lock the unit.
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
          if (res_wr) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      op_q  <= op_nxt;
      HI    <= hi_nxt;
      LO    <= lo_nxt;
    end
  end

  assign busy = (state == BUSY);

endmodule
